// File: rtl/iq_sample_reader.sv
// Byte-stream to IQ sample converter: assembles little-endian I/Q pairs from a
// FWFT byte FIFO and hands them to two independently drained output slots.

module iq_out_slot #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  free_o
);
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;

  // A slot being consumed this edge can accept a new sample on the same edge.
  assign free_o  = !valid_q || rd_en_i;
  assign data_o  = data_q;
  assign valid_o = valid_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= din_i;
      valid_q <= 1'b1;
    end else if (valid_q && rd_en_i) begin
      valid_q <= 1'b0;
    end
  end
endmodule

module iq_sample_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int QUANT_BITS = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            in_dout,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  output logic [DATA_WIDTH-1:0] i_data,
  output logic                  i_valid,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] q_data,
  output logic                  q_valid,
  input  logic                  q_rd_en
);
  localparam int NUM_CH = 2;

  typedef enum logic [2:0] {RD_ILO, RD_IHI, RD_QLO, RD_QHI, PUSH} state_t;

  state_t                           state_q, state_d;
  logic [3:0][7:0]                  bytes_q, bytes_d;
  logic                             rd, load;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] smp, dout;
  logic [NUM_CH-1:0]                rden, vld, free;

  function automatic logic [DATA_WIDTH-1:0] quant(input logic [15:0] s);
    logic [DATA_WIDTH-1:0] ext;
    ext = {{(DATA_WIDTH-16){s[15]}}, s};
    return ext << QUANT_BITS;
  endfunction

  always_comb begin
    state_d = state_q;
    bytes_d = bytes_q;
    rd      = 1'b0;
    load    = 1'b0;
    if (state_q == PUSH) begin
      if (&free) begin
        load    = 1'b1;
        state_d = RD_ILO;
      end
    end else if (!in_empty) begin
      // Read states encode the byte slot directly: RD_ILO..RD_QHI = 0..3.
      rd                      = 1'b1;
      bytes_d[state_q[1:0]]   = in_dout;
      state_d                 = state_t'(state_q + 3'd1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RD_ILO;
      bytes_q <= '0;
    end else begin
      state_q <= state_d;
      bytes_q <= bytes_d;
    end
  end

  // Gated by reset so the pop request drops the instant reset asserts.
  assign in_rd_en = rd && reset;

  assign smp[0]  = quant({bytes_q[1], bytes_q[0]});
  assign smp[1]  = quant({bytes_q[3], bytes_q[2]});
  assign rden[0] = i_rd_en;
  assign rden[1] = q_rd_en;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    iq_out_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
      .clock   (clock),
      .reset   (reset),
      .load_i  (load),
      .din_i   (smp[c]),
      .rd_en_i (rden[c]),
      .data_o  (dout[c]),
      .valid_o (vld[c]),
      .free_o  (free[c])
    );
  end

  assign i_data  = dout[0];
  assign q_data  = dout[1];
  assign i_valid = vld[0];
  assign q_valid = vld[1];
endmodule

// File: tb/tb_iq_sample_reader.sv
// Scoreboard bench for iq_sample_reader: FIFO model + expected-sample queues
// filled as bytes are issued, drained by a monitor on every consume.

module tb_iq_sample_reader;
  localparam int DW = 32;
  localparam int QB = 10;

  logic          clock, reset;
  logic [7:0]    in_dout;
  logic          in_empty, in_rd_en;
  logic [DW-1:0] i_data, q_data;
  logic          i_valid, q_valid, i_rd_en, q_rd_en;

  iq_sample_reader #(.DATA_WIDTH(DW), .QUANT_BITS(QB)) dut (
    .clock(clock), .reset(reset),
    .in_dout(in_dout), .in_empty(in_empty), .in_rd_en(in_rd_en),
    .i_data(i_data), .i_valid(i_valid), .i_rd_en(i_rd_en),
    .q_data(q_data), .q_valid(q_valid), .q_rd_en(q_rd_en)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int            n_vec = 0;
  int            n_err = 0;
  logic [7:0]    fifo[$];
  logic [7:0]    part[$];
  logic [DW-1:0] exp_i[$], exp_q[$];
  logic          gap_en = 1'b0, gap_ph = 1'b0, rnd_en = 1'b0;
  logic          i_rd_req = 1'b0, q_rd_req = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: signed 16-bit value scaled by 2^QB, wrapped to DW bits.
  function automatic logic [DW-1:0] qmodel(input logic [7:0] lo, input logic [7:0] hi);
    int v;
    v = int'($signed({hi, lo}));
    return DW'(v * (1 << QB));
  endfunction

  task automatic push_byte(input logic [7:0] b);
    fifo.push_back(b);
    part.push_back(b);
    if (part.size() == 4) begin
      exp_i.push_back(qmodel(part[0], part[1]));
      exp_q.push_back(qmodel(part[2], part[3]));
      part.delete();
    end
  endtask

  task automatic push_group(input logic [7:0] a, b, c, d);
    push_byte(a); push_byte(b); push_byte(c); push_byte(d);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  // Input FIFO model and read-enable driver; all changes land at posedge+1.
  task automatic driver();
    logic rd_s;
    forever begin
      @(negedge clock);
      rd_s = in_rd_en;
      if (in_empty) chk("in_rd_en_gate", {31'd0, in_rd_en}, 32'd0);
      @(posedge clock);
      #1;
      if (rd_s) begin
        if (fifo.size() == 0) chk("pop_empty_fifo", 32'd1, 32'd0);
        else void'(fifo.pop_front());
      end
      gap_ph   = !gap_ph;
      in_empty = (fifo.size() == 0) || (gap_en && gap_ph);
      in_dout  = (fifo.size() != 0) ? fifo[0] : 8'h00;
      i_rd_en  = rnd_en ? 1'($urandom_range(0, 1)) : i_rd_req;
      q_rd_en  = rnd_en ? 1'($urandom_range(0, 1)) : q_rd_req;
    end
  endtask

  task automatic monitor();
    logic [DW-1:0] e;
    forever begin
      @(negedge clock);
      if (reset) begin
        if (i_valid && i_rd_en) begin
          if (exp_i.size() == 0) chk("i_extra_sample", i_data, 32'hxxxxxxxx);
          else begin e = exp_i.pop_front(); chk("i_sample", i_data, e); end
        end
        if (q_valid && q_rd_en) begin
          if (exp_q.size() == 0) chk("q_extra_sample", q_data, 32'hxxxxxxxx);
          else begin e = exp_q.pop_front(); chk("q_sample", q_data, e); end
        end
      end
    end
  endtask

  task automatic wait_both_valid(input string nm);
    int k;
    k = 0;
    while (!(i_valid && q_valid) && k < 40) begin
      @(posedge clock); #6; k++;
    end
    chk(nm, {30'd0, i_valid, q_valid}, 32'd3);
  endtask

  task automatic drain();
    int k;
    i_rd_req = 1'b1; q_rd_req = 1'b1;
    k = 0;
    while ((exp_i.size() != 0 || exp_q.size() != 0 || fifo.size() != 0) && k < 3000) begin
      cyc(1); k++;
    end
    chk("drain_leftover", exp_i.size() + exp_q.size() + fifo.size(), 32'd0);
    cyc(2);
    i_rd_req = 1'b0; q_rd_req = 1'b0;
    cyc(2);
  endtask

  initial begin
    int last, cnt;
    reset    = 1'b0;
    in_empty = 1'b1;
    in_dout  = 8'h00;
    i_rd_en  = 1'b0;
    q_rd_en  = 1'b0;
    fork
      driver();
      monitor();
    join_none

    #13;
    chk("rst_i_data", i_data, 32'd0);
    chk("rst_q_data", q_data, 32'd0);
    chk("rst_valids", {29'd0, i_valid, q_valid, in_rd_en}, 32'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b1;
    cyc(1);

    // Basic group, no consumer: data must appear and hold.
    push_group(8'h34, 8'h12, 8'hCD, 8'hAB);
    wait_both_valid("t1_valid");
    chk("t1_i_data", i_data, 32'h0048D000);
    chk("t1_q_data", q_data, 32'hFEAF3400);
    cyc(4); #4;
    chk("t1_hold", {30'd0, i_valid, q_valid}, 32'd3);

    // Consume I only, then back-pressure from Q stalls the next load.
    @(posedge clock); #2;
    i_rd_req = 1'b1; cyc(1); i_rd_req = 1'b0;
    cyc(1); #4;
    chk("t2_i_drop", {30'd0, i_valid, q_valid}, 32'd1);
    @(posedge clock); #2;
    push_group(8'h00, 8'h80, 8'hFF, 8'h7F);
    cyc(10); #4;
    chk("t2_stall_valid", {30'd0, i_valid, q_valid}, 32'd1);
    chk("t2_stall_q", q_data, 32'hFEAF3400);
    @(posedge clock); #2;
    q_rd_req = 1'b1; cyc(1); q_rd_req = 1'b0;
    @(posedge clock); #6;
    chk("t2_load_valid", {30'd0, i_valid, q_valid}, 32'd3);
    chk("t2_i_data", i_data, 32'hFE000000);
    chk("t2_q_data", q_data, 32'h01FFFC00);
    drain();

    // Bursty FIFO: empty every other cycle.
    gap_en = 1'b1;
    push_group(8'h5A, 8'hC3, 8'h01, 8'h80);
    push_group(8'hFF, 8'hFF, 8'h00, 8'h00);
    drain();
    gap_en = 1'b0;

    // Streaming: 8 preloaded groups, consumers always ready.
    for (int g = 0; g < 8; g++)
      push_group(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    i_rd_req = 1'b1; q_rd_req = 1'b1;
    last = -1; cnt = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clock); #6;
      if (i_valid) begin
        if (last >= 0) chk("stream_spacing", c - last, 32'd5);
        last = c; cnt++;
      end
    end
    chk("stream_count", cnt, 32'd8);
    drain();

    // Random traffic, random gaps and random consumer stalls.
    rnd_en = 1'b1;
    for (int g = 0; g < 24; g++) begin
      gap_en = 1'($urandom_range(0, 1));
      push_group(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      cyc($urandom_range(0, 6));
    end
    rnd_en = 1'b0; gap_en = 1'b0;
    drain();

    // Reset mid-frame with outputs valid and a pop pending.
    push_group(8'h10, 8'h20, 8'h30, 8'h40);
    wait_both_valid("t5_pre_valid");
    @(posedge clock); #2;
    push_byte(8'h11); push_byte(8'h22);
    cyc(6);
    push_byte(8'h33);
    @(posedge clock); #3;
    chk("t5_pre_rd_en", {31'd0, in_rd_en}, 32'd1);
    reset = 1'b0;
    #1;
    chk("t5_async_clear", {29'd0, i_valid, q_valid, in_rd_en}, 32'd0);
    fifo.delete(); part.delete(); exp_i.delete(); exp_q.delete();
    cyc(2);
    @(negedge clock);
    reset = 1'b1;
    cyc(1);
    push_group(8'h01, 8'h00, 8'h02, 8'h00);
    wait_both_valid("t5_post_valid");
    chk("t5_i_data", i_data, 32'h00000400);
    chk("t5_q_data", q_data, 32'h00000800);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "timeout");
  end
endmodule
